data_bus_responder: RTL and testbench
=====================================

// Module: data_bus_responder
// PURPOSE
//  Responder for the rv32 data memory bus: the slave end of the address/read/write/mask/ready/fault
//  handshake that the core drives. Backs the bus with a word-organised RAM with byte-lane writes.
//  Inserts a configurable number of wait states and flags out-of-range accesses with fault.
//  Sits between rv32 data port and on-chip RAM in SoC top-level and in formal/sim harnesses.
// PARAMETERS
//  DEPTH_WORDS  1024          RAM size in 32-bit words; power of two, >= 2
//  BASE_ADDR    32'h0001_0000 byte address of word 0; aligned to 4*DEPTH_WORDS
//  WAIT_STATES  1             extra cycles before ready; 0..15
// PORTS
//  clk                  in   1   clock, all logic rising-edge
//  reset_n              in   1   asynchronous active-low reset
//  data_address_in      in   32  byte address; bits [1:0] ignored
//  data_read_in         in   1   read request, held until ready_out
//  data_write_in        in   1   write request, held until ready_out
//  data_write_mask_in   in   4   byte-lane enables; bit i -> bits [8i+7:8i]
//  data_write_value_in  in   32  write data
//  data_read_value_out  out  32  read data, valid in ready cycle
//  data_ready_out       out  1   one-cycle completion pulse
//  data_fault_out       out  1   access error; valid only with ready
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, wait counter=0, ready=0, fault=0,
//    read_value=0. RAM contents are not reset.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. IDLE: on (read|write) latch address/mask/value/kind,
//    compute in_range = (addr - BASE_ADDR) < 4*DEPTH_WORDS (32-bit unsigned, wraps below BASE).
//    Go to WAIT with counter=WAIT_STATES-1; if WAIT_STATES==0 go straight to RESP.
//  - WAIT: decrement counter; at 0 go to RESP. If read and write both drop in WAIT, abort to
//    IDLE: no write, no ready.
//  - RESP: ready_out=1 for exactly this cycle, fault_out=!in_range.
//    Write+in_range: commit masked lanes at the RESP edge. Mask 0 is a legal no-op.
//    Read+in_range: read_value_out = word at index; fault: read_value_out=0, RAM untouched.
//  - Latency: request first seen in cycle N -> ready in cycle N+1+WAIT_STATES.
//  - Back-to-back: cycle after RESP is IDLE and samples a new request.
//    A request held across ready is a new transaction, by design.
//  - read & write both set: treated as write; read_value_out returns the pre-write word.
//  - Latched request fields govern the transaction; input changes after IDLE are ignored.
//  - read_value_out holds its last value outside the ready cycle. fault_out=0 when ready=0.
//  - Reset mid-transaction: immediate return to IDLE, no write commit, no ready pulse.
//  - Word index = (addr - BASE_ADDR)[log2(4*DEPTH_WORDS)-1:2]; no wrap into RAM when out of range.
// STRUCTURE
//  - Package data_bus_pkg: state enum {IDLE, WAIT, RESP}, WORD_W=32, MASK_W=4,
//    function in_range(addr, base, depth).
//  - Sub-module byte_ram (DEPTH_WORDS x 32, sync read, per-byte write enables, one port)
//    instantiated once. FSM, counter and request latch stay in this module.
// TESTING
//  - Write 0xDEADBEEF mask 4'hF @BASE+0x10, then read @BASE+0x10 -> ready at
//    N+1+WAIT_STATES, value 0xDEADBEEF, fault 0.
//  - Write 0x000000AA mask 4'b0001 over 0x11223344 -> read gives 0x112233AA;
//    mask 4'b0000 leaves word unchanged.
//  - Read @BASE-4 and @BASE+4*DEPTH_WORDS -> ready with fault 1, value 0.
//    Faulting write leaves RAM unchanged; word 0 and last word are accessible.
//  - WAIT_STATES=0 and =3 -> ready exactly 1 / 4 cycles after request.
//    Back-to-back reads with no idle cycle each complete.
//  - reset_n low during WAIT of a write -> no ready, RAM unchanged.
//    Request dropped mid-WAIT -> no ready, no commit.
//  - read & write together (old 0x55555555, write 0xAAAAAAAA) -> read_value 0x55555555;
//    RAM then holds 0xAAAAAAAA.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared types and helpers for the rv32 data-bus responder.
package data_bus_pkg;

  localparam int WORD_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Unsigned wrap makes addresses below base land far above the window.
  function automatic logic in_range(input logic [WORD_W-1:0] addr,
                                    input logic [WORD_W-1:0] base,
                                    input int unsigned       depth);
    logic [WORD_W-1:0] offset;
    logic [WORD_W-1:0] span;
    offset = addr - base;
    span   = depth << 2;
    return offset < span;
  endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// Data-bus handshake between the rv32 core (master) and its memory responder (slave).
interface data_bus_if;
  import data_bus_pkg::*;

  logic [WORD_W-1:0] data_address_in;
  logic              data_read_in;
  logic              data_write_in;
  logic [MASK_W-1:0] data_write_mask_in;
  logic [WORD_W-1:0] data_write_value_in;
  logic [WORD_W-1:0] data_read_value_out;
  logic              data_ready_out;
  logic              data_fault_out;

  modport master (
    output data_address_in, data_read_in, data_write_in,
           data_write_mask_in, data_write_value_in,
    input  data_read_value_out, data_ready_out, data_fault_out
  );

  modport slave (
    input  data_address_in, data_read_in, data_write_in,
           data_write_mask_in, data_write_value_in,
    output data_read_value_out, data_ready_out, data_fault_out
  );

endinterface

// File: rtl/data_bus_responder_byte_ram.sv
// Single-port word RAM with synchronous read and per-byte write enables.
module byte_ram
  import data_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic              we,
  input  logic [MASK_W-1:0] be,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Read returns the word as it was before a write on the same edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_bus_responder.sv
// Slave end of the rv32 data bus: wait-state FSM, request latch and range check over byte_ram.
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [WORD_W-1:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned       WAIT_STATES = 1
) (
  input logic       clk,
  input logic       reset_n,
  data_bus_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t            state;
  state_t            state_nx;
  logic [3:0]        cnt;
  logic              req;
  logic              accept;
  logic [WORD_W-1:0] offset;
  logic [AW-1:0]     idx_in;
  logic [AW-1:0]     idx_q;
  logic [MASK_W-1:0] mask_q;
  logic [WORD_W-1:0] wdata_q;
  logic              is_write_q;
  logic              in_range_q;
  logic [WORD_W-1:0] rvalue_q;
  logic [WORD_W-1:0] resp_value;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign req    = bus.data_read_in | bus.data_write_in;
  assign accept = (state == IDLE) && req;
  assign offset = bus.data_address_in - BASE_ADDR;
  assign idx_in = AW'(offset >> 2);

  // RAM is addressed straight from the bus in IDLE so a zero-wait read has data in RESP.
  assign ram_addr = (state == IDLE) ? idx_in : idx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req) state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: begin
        if (!req)          state_nx = IDLE;
        else if (cnt == 0) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.data_ready_out      = 1'b0;
    bus.data_fault_out      = 1'b0;
    resp_value              = rvalue_q;
    ram_we                  = 1'b0;
    if (state == RESP) begin
      bus.data_ready_out = 1'b1;
      bus.data_fault_out = !in_range_q;
      resp_value         = in_range_q ? ram_rdata : '0;
      ram_we             = is_write_q && in_range_q;
    end
    bus.data_read_value_out = resp_value;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 4'd0;
      is_write_q <= 1'b0;
      in_range_q <= 1'b0;
      rvalue_q   <= '0;
    end else begin
      if (accept) begin
        cnt        <= CNT_INIT;
        is_write_q <= bus.data_write_in;
        in_range_q <= in_range(bus.data_address_in, BASE_ADDR, DEPTH_WORDS);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == RESP) rvalue_q <= resp_value;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= idx_in;
      mask_q  <= bus.data_write_mask_in;
      wdata_q <= bus.data_write_value_in;
    end
  end

  byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .be   (mask_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench: three responders (0, 1 and 3 wait states) against a word-array reference model.
`timescale 1ns/1ps
module tb_data_bus_responder;

  localparam int          NDUT    = 3;
  localparam int unsigned DEPTH   = 64;
  localparam logic [31:0] BASE    = 32'h0001_0000;
  localparam int          TIMEOUT = 40;

  typedef struct {
    longint      due;
    logic        chk_val;
    logic [31:0] value;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] address [NDUT];
  logic        rd      [NDUT];
  logic        wr      [NDUT];
  logic [3:0]  mask    [NDUT];
  logic [31:0] wvalue  [NDUT];
  logic [31:0] rvalue  [NDUT];
  logic        ready   [NDUT];
  logic        fault   [NDUT];

  exp_t        exp_q   [NDUT][$];
  logic [31:0] ref_mem [NDUT][DEPTH];
  longint      cyc = 0;
  int          vectors = 0;
  int          errors = 0;

  function automatic int ws_of(input int g);
    return (g == 0) ? 3 : (g == 1) ? 0 : 1;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    localparam int unsigned WS = (g == 0) ? 3 : (g == 1) ? 0 : 1;
    data_bus_if bus ();
    assign bus.data_address_in     = address[g];
    assign bus.data_read_in        = rd[g];
    assign bus.data_write_in       = wr[g];
    assign bus.data_write_mask_in  = mask[g];
    assign bus.data_write_value_in = wvalue[g];
    assign rvalue[g]               = bus.data_read_value_out;
    assign ready[g]                = bus.data_ready_out;
    assign fault[g]                = bus.data_fault_out;
    data_bus_responder #(
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (BASE),
      .WAIT_STATES(WS)
    ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, g, cyc, act, exp);
    end
  endtask

  // Monitor: pop one expectation per ready pulse.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < NDUT; g++) begin
      if (ready[g] === 1'b1) begin
        if (exp_q[g].size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_ready dut%0d cycle %0d: got ready 1 expected 0", g, cyc);
        end else begin
          e = exp_q[g].pop_front();
          check("latency", g, 64'(cyc), 64'(e.due));
          check("fault", g, 64'(fault[g]), 64'(e.fault));
          if (e.chk_val) check("read_value", g, 64'(rvalue[g]), 64'(e.value));
        end
      end else if (fault[g] !== 1'b0) begin
        vectors++;
        errors++;
        $display("FAIL fault_without_ready dut%0d cycle %0d: got %b expected 0", g, cyc, fault[g]);
      end
    end
  end

  // Issue one transaction, record the expected response, wait for ready.
  task automatic txn(input int g, input logic [31:0] addr, input logic r, input logic w,
                     input logic [3:0] m, input logic [31:0] v, input bit b2b, input bit keep);
    exp_t        e;
    logic [31:0] off;
    logic        ir;
    int unsigned idx;
    longint      n;
    int          k;
    if (!b2b) begin
      @(posedge clk);
      @(negedge clk);
      n = cyc;
    end else begin
      n = cyc + 1;
    end
    off       = addr - BASE;
    ir        = off < 4 * DEPTH;
    idx       = ir ? off / 4 : 0;
    e.due     = n + 1 + ws_of(g);
    e.chk_val = r;
    e.fault   = !ir;
    e.value   = ir ? ref_mem[g][idx] : 32'h0;
    if (w && ir) begin
      for (int i = 0; i < 4; i++) if (m[i]) ref_mem[g][idx][8*i +: 8] = v[8*i +: 8];
    end
    exp_q[g].push_back(e);
    address[g] = addr;
    rd[g]      = r;
    wr[g]      = w;
    mask[g]    = m;
    wvalue[g]  = v;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (ready[g] !== 1'b1 && k < TIMEOUT);
    if (ready[g] !== 1'b1) begin
      vectors++;
      errors++;
      $display("FAIL ready_timeout dut%0d: got no ready in %0d cycles expected ready", g, TIMEOUT);
      void'(exp_q[g].pop_back());
    end
    if (!keep) begin
      rd[g] = 1'b0;
      wr[g] = 1'b0;
    end
  endtask

  task automatic rd_word(input int g, input logic [31:0] addr);
    txn(g, addr, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wr_word(input int g, input logic [31:0] addr, input logic [3:0] m, input logic [31:0] v);
    txn(g, addr, 1'b0, 1'b1, m, v, 1'b0, 1'b0);
  endtask

  // Write request withdrawn (or reset pulsed) while waiting; must leave no trace.
  task automatic interrupted_write(input int g, input logic [31:0] addr, input logic [31:0] v, input bit use_reset);
    @(posedge clk);
    @(negedge clk);
    address[g] = addr;
    wr[g]      = 1'b1;
    mask[g]    = 4'hF;
    wvalue[g]  = v;
    @(posedge clk);
    #1;
    if (use_reset) begin
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      wr[g]   = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
    end else begin
      wr[g] = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          sel;
    int          kind;
    bit          prev_keep;
    bit          keep;
    for (int g = 0; g < NDUT; g++) begin
      rd[g]      = 1'b0;
      wr[g]      = 1'b0;
      mask[g]    = 4'h0;
      address[g] = 32'h0;
      wvalue[g]  = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check("reset_ready", g, 64'(ready[g]), 64'h0);
      check("reset_fault", g, 64'(fault[g]), 64'h0);
      check("reset_read_value", g, 64'(rvalue[g]), 64'h0);
    end
    reset_n = 1'b1;

    for (int g = 0; g < NDUT; g++) begin
      for (int i = 0; i < int'(DEPTH); i++) wr_word(g, BASE + 4 * i, 4'hF, $urandom);

      wr_word(g, BASE + 32'h10, 4'hF, 32'hDEADBEEF);
      rd_word(g, BASE + 32'h10);
      wr_word(g, BASE + 32'h20, 4'hF, 32'h11223344);
      wr_word(g, BASE + 32'h20, 4'b0001, 32'h000000AA);
      rd_word(g, BASE + 32'h20);
      wr_word(g, BASE + 32'h20, 4'b0000, 32'hFFFFFFFF);
      rd_word(g, BASE + 32'h20);

      rd_word(g, BASE - 4);
      rd_word(g, BASE + 4 * DEPTH);
      wr_word(g, BASE, 4'hF, 32'h01020304);
      wr_word(g, BASE + 4 * (DEPTH - 1), 4'hF, 32'hA5A55A5A);
      wr_word(g, BASE + 4 * DEPTH, 4'hF, 32'hFFFFFFFF);
      wr_word(g, BASE - 4, 4'hF, 32'hFFFFFFFF);
      rd_word(g, BASE);
      rd_word(g, BASE + 4 * (DEPTH - 1));

      wr_word(g, BASE + 32'h30, 4'hF, 32'h55555555);
      txn(g, BASE + 32'h30, 1'b1, 1'b1, 4'hF, 32'hAAAAAAAA, 1'b0, 1'b0);
      rd_word(g, BASE + 32'h30);

      txn(g, BASE + 32'h10, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
      txn(g, BASE + 32'h20, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
      txn(g, BASE + 32'h30, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);

      if (ws_of(g) > 0) begin
        interrupted_write(g, BASE + 32'h40, 32'hCAFEF00D, 1'b0);
        rd_word(g, BASE + 32'h40);
      end
    end

    interrupted_write(0, BASE + 32'h44, 32'h0BADF00D, 1'b1);
    rd_word(0, BASE + 32'h44);

    for (int g = 0; g < NDUT; g++) begin
      prev_keep = 1'b0;
      for (int t = 0; t < 120; t++) begin
        sel = $urandom_range(0, 9);
        if (sel < 7)       a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3);
        else if (sel == 7) a = BASE - 4 * $urandom_range(1, 8);
        else if (sel == 8) a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 8);
        else               a = $urandom;
        kind = $urandom_range(0, 2);
        keep = (t == 119) ? 1'b0 : 1'($urandom_range(0, 1));
        txn(g, a, kind != 1, kind != 0, 4'($urandom_range(0, 15)), $urandom, prev_keep, keep);
        prev_keep = keep;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) check("pending_at_end", g, 64'(exp_q[g].size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
